// File: rtl/param_sequence_detector.sv
// Serial pattern detector with a runtime-loadable pattern and overlap control.
// Define SEQ_DET_COUNT_EN to add the saturating matchCount output.
module param_sequence_detector #(
   parameter int                 SEQ_LEN     = 15,
   parameter logic [SEQ_LEN-1:0] SEQ_DEFAULT = 15'b101001100110011,
   parameter int                 CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dataIn,
   input  logic               dataValid,
   input  logic               seqLoad,
   input  logic [SEQ_LEN-1:0] seqIn,
   input  logic               overlapEn,
`ifdef SEQ_DET_COUNT_EN
   output logic               detected,
   output logic [CNT_W-1:0]   matchCount
`else
   output logic               detected
`endif
);

   localparam int BW = $clog2(SEQ_LEN + 1);

   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] ARMED = 1'b1;

   logic [SEQ_LEN-1:0] pat_reg;
   logic [SEQ_LEN-1:0] shift_reg;
   logic [BW-1:0]      bit_cnt;
   logic [0:0]         state;

   logic [SEQ_LEN-1:0] window;
   logic               accept;
   logic               window_full;
   logic               match;

   // A match needs the accepted bit to complete or extend a full window, so a
   // partially filled window can never alias the (possibly all-zero) pattern.
   always_comb begin
      window      = {shift_reg[SEQ_LEN-2:0], dataIn};
      accept      = dataValid && !seqLoad;
      window_full = (state == ARMED) || (bit_cnt == BW'(SEQ_LEN - 1));
      match       = accept && window_full && (window == pat_reg);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_reg   <= SEQ_DEFAULT;
         shift_reg <= '0;
         bit_cnt   <= '0;
         state     <= FILL;
         detected  <= 1'b0;
      end else if (seqLoad) begin
         pat_reg   <= seqIn;
         shift_reg <= '0;
         bit_cnt   <= '0;
         state     <= FILL;
         detected  <= 1'b0;
      end else begin
         detected <= match;
         if (accept) begin
            shift_reg <= window;
            if (match && !overlapEn) begin
               bit_cnt <= '0;
               state   <= FILL;
            end else if (state == FILL) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BW'(SEQ_LEN - 1)) begin
                  state <= ARMED;
               end
            end
         end
      end
   end

`ifdef SEQ_DET_COUNT_EN
   // Survives seqLoad on purpose: only reset clears the running total.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         matchCount <= '0;
      end else if (match && (matchCount != {CNT_W{1'b1}})) begin
         matchCount <= matchCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector (SEQ_LEN=4, pattern 1011, CNT_W=2).
module tb_param_sequence_detector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dataIn = 1'b0;
   logic       dataValid = 1'b0;
   logic       seqLoad = 1'b0;
   logic [3:0] seqIn = 4'b0000;
   logic       overlapEn = 1'b1;
   logic       detected;
`ifdef SEQ_DET_COUNT_EN
   logic [1:0] matchCount;
`endif

   int passed = 0;
   int total = 0;
   logic [0:0] exp_q[$];

   param_sequence_detector #(
      .SEQ_LEN(4),
      .SEQ_DEFAULT(4'b1011),
      .CNT_W(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dataIn(dataIn),
      .dataValid(dataValid),
      .seqLoad(seqLoad),
      .seqIn(seqIn),
      .overlapEn(overlapEn),
`ifdef SEQ_DET_COUNT_EN
      .detected(detected),
      .matchCount(matchCount)
`else
      .detected(detected)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Drive one cycle, push the expected detected value, then pop and compare.
   task automatic step(input logic v, input logic d, input logic ld, input logic [3:0] si,
                       input logic e, input string tag);
      logic [0:0] expv;
      dataValid = v;
      dataIn    = d;
      seqLoad   = ld;
      seqIn     = si;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      expv = exp_q.pop_front();
      check(tag, {31'd0, detected}, {31'd0, expv});
      seqLoad   = 1'b0;
      dataValid = 1'b0;
   endtask

   // Feed n valid bits MSB first; exps holds the expected pulse after each bit.
   task automatic run_stream(input logic [31:0] bits, input logic [31:0] exps, input int n,
                             input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b1, bits[i], 1'b0, 4'b0000, exps[i], tag);
      end
   endtask

   // Reset with load and valid asserted so reset priority is exercised.
   task automatic do_reset();
      rst_n     = 1'b0;
      dataValid = 1'b1;
      dataIn    = 1'b1;
      seqLoad   = 1'b1;
      seqIn     = 4'b0000;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      dataValid = 1'b0;
      seqLoad   = 1'b0;
      check("reset_detected", {31'd0, detected}, 32'd0);
      check("reset_bitcnt", 32'(dut.bit_cnt), 32'd0);
`ifdef SEQ_DET_COUNT_EN
      check("reset_count", {30'd0, matchCount}, 32'd0);
`endif
   endtask

   initial begin
      do_reset();

      overlapEn = 1'b1;
      run_stream(32'b1011011, 32'b0001001, 7, "overlap");

      do_reset();
      overlapEn = 1'b0;
      run_stream(32'b1011011, 32'b0001000, 7, "non_overlap");

      step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "load_zero");
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "zero_bit1");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "zero_gap1");
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "zero_bit2");
      step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "zero_gap2");
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "zero_bit3");
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, "zero_bit4");

      overlapEn = 1'b1;
      run_stream(32'b101, 32'b000, 3, "pre_reset");
      do_reset();
      run_stream(32'b1011, 32'b0001, 4, "post_reset");

      run_stream(32'b101, 32'b000, 3, "load_prio_pre");
      step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, "load_prio_edge");
      check("load_prio_bitcnt", 32'(dut.bit_cnt), 32'd0);
      run_stream(32'b1011, 32'b0001, 4, "load_prio_post");

`ifdef SEQ_DET_COUNT_EN
      do_reset();
      overlapEn = 1'b1;
      run_stream(32'b1011, 32'b0001, 4, "cnt_m1");
      check("count_1", {30'd0, matchCount}, 32'd1);
      run_stream(32'b011, 32'b001, 3, "cnt_m2");
      check("count_2", {30'd0, matchCount}, 32'd2);
      run_stream(32'b011, 32'b001, 3, "cnt_m3");
      check("count_3", {30'd0, matchCount}, 32'd3);
      run_stream(32'b011, 32'b001, 3, "cnt_m4");
      check("count_sat4", {30'd0, matchCount}, 32'd3);
      run_stream(32'b011, 32'b001, 3, "cnt_m5");
      check("count_sat5", {30'd0, matchCount}, 32'd3);
      step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, "cnt_load");
      check("count_after_load", {30'd0, matchCount}, 32'd3);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/param_sequence_detector.md
PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

Interface
REQ-001 Parameter SEQ_LEN, default 15, pattern length in bits; legal range 2..32.
REQ-002 Parameter SEQ_DEFAULT, default 15'b101001100110011, pattern loaded at reset; width SEQ_LEN.
REQ-003 Parameter CNT_W, default 8, match-counter width; legal range 1..16.
REQ-004 Port list; the block SHALL use one clock and a synchronous, active-low reset:
  clk  input  1  rising-edge clock.
  rst_n  input  1  synchronous active-low reset.
  dataIn  input  1  serial data bit.
  dataValid  input  1  dataIn is sampled only when high.
  seqLoad  input  1  one-cycle strobe; loads a new pattern from seqIn.
  seqIn  input  SEQ_LEN  new pattern; MSB is the oldest bit.
  overlapEn  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
  detected  output  1  registered one-cycle match pulse.
  matchCount  output  CNT_W  saturating match count; present only with SEQ_DET_COUNT_EN.

Function
REQ-005 The block SHALL hold the pattern register patReg (SEQ_LEN bits), the window shift register shiftReg (SEQ_LEN bits) and the fill counter bitCnt (0..SEQ_LEN).
REQ-006 On an edge with dataValid=1 and seqLoad=0, the block SHALL set shiftReg <= {shiftReg[SEQ_LEN-2:0], dataIn}; with dataValid=0, shiftReg and bitCnt SHALL hold.
REQ-007 The FSM SHALL have two states:
  FILL: bitCnt < SEQ_LEN; bitCnt increments on each accepted bit.
  ARMED: the window is full; bitCnt holds at SEQ_LEN.
REQ-008 FILL SHALL move to ARMED on the edge that accepts the bit making bitCnt equal SEQ_LEN.
REQ-009 A match SHALL be the edge where the new window {shiftReg[SEQ_LEN-2:0], dataIn} equals patReg and the accepted bit completes or sits in a full window. Matches from a partially filled window SHALL be impossible, including the all-zero pattern right after reset.
REQ-010 On a match, detected SHALL be 1 for exactly the next cycle (latency 1 from the edge that accepts the last bit). Otherwise detected SHALL be 0.
REQ-011 When a match occurs with overlapEn=1, the state SHALL remain ARMED.
REQ-012 When a match occurs with overlapEn=0, bitCnt SHALL clear to 0 and the state SHALL go to FILL, so the next match needs SEQ_LEN fresh accepted bits.
REQ-013 overlapEn SHALL be sampled on each match edge; changing it while no match occurs SHALL have no effect.
REQ-014 On seqLoad=1, the block SHALL:
  load patReg <= seqIn;
  clear shiftReg and bitCnt;
  enter FILL;
  ignore dataValid in that cycle;
  drive detected=0 on the following cycle.
REQ-015 seqLoad asserted on a would-be match edge SHALL take priority; no detected pulse SHALL result.
REQ-016 Back-to-back matches (overlap mode, periodic pattern) SHALL give detected high on consecutive cycles, one pulse per match.

Reset
REQ-017 When rst_n=0 at a rising clk edge, the block SHALL set:
  patReg = SEQ_DEFAULT;
  shiftReg = 0;
  bitCnt = 0;
  state = FILL;
  detected = 0;
  matchCount = 0.
REQ-018 Reset SHALL override seqLoad and dataValid.
REQ-019 A reset mid-sequence SHALL discard all partially received bits.
REQ-020 Any runtime-loaded pattern SHALL be lost on reset.

Configuration
REQ-021 With the macro SEQ_DET_COUNT_EN defined:
  the matchCount port and counter SHALL exist;
  matchCount SHALL increment by 1 on each edge where detected is set;
  matchCount SHALL saturate at 2^CNT_W-1;
  matchCount SHALL clear only on reset, not on seqLoad.
REQ-022 With SEQ_DET_COUNT_EN undefined, the matchCount port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification (bench uses SEQ_LEN=4, SEQ_DEFAULT=4'b1011, CNT_W=2)
REQ-023 Overlap: overlapEn=1, stream 1,0,1,1,0,1,1 with dataValid=1 -> detected pulses after bit 4 and bit 7.
REQ-024 Non-overlap: overlapEn=0, same stream -> a single pulse after bit 4.
REQ-025 Zero pattern and gaps:
  seqLoad with seqIn=4'b0000 -> no pulse during the first 3 accepted zeros, pulse after the 4th;
  dataValid=0 cycles interleaved -> bits held, pulse only after the 4th valid bit.
REQ-026 Reset mid-operation: 1,0,1 accepted, rst_n=0 for 1 cycle, then 1 -> no pulse; pattern is back to 1011.
REQ-027 Load priority: seqLoad=1 on the edge accepting the final 1 of 1011 -> detected stays 0; bitCnt=0 afterwards.
REQ-028 Counter (SEQ_DET_COUNT_EN defined): 5 overlapping matches of 1011 -> matchCount 1,2,3,3,3.
